// File: rtl/flag_reg_shadow.sv
// C/Z flag register with a LIFO shadow stack. Interrupt entry pushes the flags,
// and RETIE pops them. Sticky overflow and underflow flags record stack misuse.
module flag_reg_shadow #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             C_IN,
    input  logic             Z_IN,
    input  logic             FLG_C_SET,
    input  logic             FLG_C_CLR,
    input  logic             FLG_C_LD,
    input  logic             FLG_Z_LD,
    input  logic             FLG_LD_SEL,
    input  logic             FLG_SHAD_PUSH,
    input  logic             FLG_SHAD_POP,
    input  logic             FLG_ERR_CLR,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic [PTR_W-1:0] SHAD_DEPTH,
    output logic             SHAD_OVF,
    output logic             SHAD_UNF
);

    localparam logic [PTR_W-1:0] DEPTH_MAX = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

    logic             c_r;
    logic             z_r;
    logic [PTR_W-1:0] depth_r;
    logic             ovf_r;
    logic             unf_r;
    logic [1:0]       stack_r [DEPTH];

    logic             full_s;
    logic             empty_s;
    logic [1:0]       top_s;
    logic             src_c_s;
    logic             src_z_s;
    logic             c_nxt_s;
    logic             z_nxt_s;
    logic [PTR_W-1:0] depth_nxt_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;

    assign full_s  = (depth_r == DEPTH_MAX);
    assign empty_s = (depth_r == {PTR_W{1'b0}});

    // Stack top lookup from current state; an empty stack reads as {0,0}.
    always_comb begin
        top_s = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (depth_r == PTR_W'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    // Stack pointer, write target and error events for this cycle.
    always_comb begin
        depth_nxt_s = depth_r;
        wr_en_s     = 1'b0;
        wr_ptr_s    = depth_r;
        ovf_evt_s   = 1'b0;
        unf_evt_s   = 1'b0;
        case ({FLG_SHAD_PUSH, FLG_SHAD_POP})
            2'b10: begin
                if (full_s) begin
                    ovf_evt_s = 1'b1;
                end else begin
                    wr_en_s     = 1'b1;
                    depth_nxt_s = depth_r + ONE;
                end
            end
            2'b01: begin
                if (empty_s) begin
                    unf_evt_s = 1'b1;
                end else begin
                    depth_nxt_s = depth_r - ONE;
                end
            end
            2'b11: begin
                // Push plus pop replaces the top in place; on an empty stack it is a plain push.
                wr_en_s = 1'b1;
                if (empty_s) begin
                    depth_nxt_s = depth_r + ONE;
                end else begin
                    wr_ptr_s = depth_r - ONE;
                end
            end
            default: begin
                depth_nxt_s = depth_r;
            end
        endcase
    end

    // Flag next-state: clear beats set beats load; Z only loads.
    always_comb begin
        src_c_s = FLG_LD_SEL ? top_s[1] : C_IN;
        src_z_s = FLG_LD_SEL ? top_s[0] : Z_IN;
        if (FLG_C_CLR) begin
            c_nxt_s = 1'b0;
        end else if (FLG_C_SET) begin
            c_nxt_s = 1'b1;
        end else if (FLG_C_LD) begin
            c_nxt_s = src_c_s;
        end else begin
            c_nxt_s = c_r;
        end
        z_nxt_s   = FLG_Z_LD ? src_z_s : z_r;
        ovf_nxt_s = ovf_evt_s | (ovf_r & ~FLG_ERR_CLR);
        unf_nxt_s = unf_evt_s | (unf_r & ~FLG_ERR_CLR);
    end

    // Flag, depth and sticky error registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c_r     <= 1'b0;
            z_r     <= 1'b0;
            depth_r <= {PTR_W{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            c_r     <= c_nxt_s;
            z_r     <= z_nxt_s;
            depth_r <= depth_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Shadow stack storage saves the pre-edge flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_s && (wr_ptr_s == PTR_W'(i))) begin
                    stack_r[i] <= {c_r, z_r};
                end
            end
        end
    end

    assign C_FLAG     = c_r;
    assign Z_FLAG     = z_r;
    assign SHAD_DEPTH = depth_r;
    assign SHAD_OVF   = ovf_r;
    assign SHAD_UNF   = unf_r;

endmodule

// File: tb/tb_flag_reg_shadow.sv
// Directed bench for flag_reg_shadow. It checks the C/Z priority, save and restore,
// nesting, the overflow and underflow flags, and simultaneous push and pop.
module tb_flag_reg_shadow;

    localparam int DEPTH = 4;
    localparam int PTR_W = 3;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             C_IN, Z_IN;
    logic             FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL;
    logic             FLG_SHAD_PUSH, FLG_SHAD_POP, FLG_ERR_CLR;
    logic             C_FLAG, Z_FLAG, SHAD_OVF, SHAD_UNF;
    logic [PTR_W-1:0] SHAD_DEPTH;

    int n_vec  = 0;
    int n_miss = 0;

    logic [1:0] exp_pop [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

    always #5 CLK = ~CLK;

    flag_reg_shadow #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
        .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL),
        .FLG_SHAD_PUSH(FLG_SHAD_PUSH), .FLG_SHAD_POP(FLG_SHAD_POP),
        .FLG_ERR_CLR(FLG_ERR_CLR), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
        .SHAD_DEPTH(SHAD_DEPTH), .SHAD_OVF(SHAD_OVF), .SHAD_UNF(SHAD_UNF)
    );

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic c, input logic z, input int d);
        chk_val({tag, "_c"}, {7'd0, C_FLAG}, {7'd0, c});
        chk_val({tag, "_z"}, {7'd0, Z_FLAG}, {7'd0, z});
        chk_val({tag, "_depth"}, {5'd0, SHAD_DEPTH}, 8'(d));
    endtask

    task automatic idle();
        C_IN = 1'b0; Z_IN = 1'b0;
        FLG_C_SET = 1'b0; FLG_C_CLR = 1'b0; FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0;
        FLG_LD_SEL = 1'b0; FLG_SHAD_PUSH = 1'b0; FLG_SHAD_POP = 1'b0; FLG_ERR_CLR = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic load(input logic c, input logic z);
        C_IN = c; Z_IN = z; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    endtask

    task automatic retie();
        FLG_LD_SEL = 1'b1; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1; FLG_SHAD_POP = 1'b1;
    endtask

    // Leaves the stack holding {1,1},{0,1},{1,0},{0,0} bottom to top, with flags {0,0}.
    task automatic fill_stack();
        load(1'b1, 1'b1); tick();
        load(1'b0, 1'b1); FLG_SHAD_PUSH = 1'b1; tick();
        load(1'b1, 1'b0); FLG_SHAD_PUSH = 1'b1; tick();
        load(1'b0, 1'b0); FLG_SHAD_PUSH = 1'b1; tick();
        FLG_SHAD_PUSH = 1'b1; tick();
    endtask

    task automatic drain_stack(input string tag);
        for (int i = 0; i < 4; i++) begin
            retie(); tick();
            chk_st($sformatf("%s_pop%0d", tag, i), exp_pop[i][1], exp_pop[i][0], 3 - i);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        chk_st("reset", 1'b0, 1'b0, 0);
        chk_val("reset_ovf", {7'd0, SHAD_OVF}, 8'd0);
        chk_val("reset_unf", {7'd0, SHAD_UNF}, 8'd0);
        RST_N = 1'b1;

        C_IN = 1'b1; FLG_C_LD = 1'b1; FLG_C_SET = 1'b1; FLG_C_CLR = 1'b1; tick();
        chk_val("prio_clr", {7'd0, C_FLAG}, 8'd0);
        C_IN = 1'b1; FLG_C_LD = 1'b1; FLG_C_SET = 1'b1; tick();
        chk_val("prio_set", {7'd0, C_FLAG}, 8'd1);
        C_IN = 1'b0; FLG_C_LD = 1'b1; FLG_C_SET = 1'b1; tick();
        chk_val("set_over_ld", {7'd0, C_FLAG}, 8'd1);
        C_IN = 1'b0; FLG_C_LD = 1'b1; tick();
        chk_val("ld_c", {7'd0, C_FLAG}, 8'd0);
        Z_IN = 1'b1; FLG_Z_LD = 1'b1; tick();
        chk_st("ld_z", 1'b0, 1'b1, 0);
        tick();
        chk_st("hold", 1'b0, 1'b1, 0);

        FLG_C_SET = 1'b1; FLG_SHAD_PUSH = 1'b1; tick();
        chk_st("pre_rst", 1'b1, 1'b1, 1);
        #3 RST_N = 1'b0;
        #1 chk_st("async_rst", 1'b0, 1'b0, 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;

        load(1'b1, 1'b0); tick();
        FLG_SHAD_PUSH = 1'b1; tick();
        chk_st("push1", 1'b1, 1'b0, 1);
        load(1'b0, 1'b1); tick();
        chk_st("alu", 1'b0, 1'b1, 1);
        retie(); tick();
        chk_st("restore", 1'b1, 1'b0, 0);

        fill_stack();
        chk_st("nest_full", 1'b0, 1'b0, 4);
        load(1'b1, 1'b1); tick();
        drain_stack("nest");

        fill_stack();
        load(1'b1, 1'b1); tick();
        FLG_SHAD_PUSH = 1'b1; tick();
        chk_st("ovf", 1'b1, 1'b1, 4);
        chk_val("ovf_flag", {7'd0, SHAD_OVF}, 8'd1);
        FLG_ERR_CLR = 1'b1; tick();
        chk_val("ovf_clr", {7'd0, SHAD_OVF}, 8'd0);
        FLG_SHAD_PUSH = 1'b1; FLG_ERR_CLR = 1'b1; tick();
        chk_val("ovf_set_wins", {7'd0, SHAD_OVF}, 8'd1);
        FLG_ERR_CLR = 1'b1; tick();
        chk_val("ovf_clr2", {7'd0, SHAD_OVF}, 8'd0);
        drain_stack("ovf");

        retie(); tick();
        chk_st("unf", 1'b0, 1'b0, 0);
        chk_val("unf_flag", {7'd0, SHAD_UNF}, 8'd1);
        FLG_ERR_CLR = 1'b1; tick();
        chk_val("unf_clr", {7'd0, SHAD_UNF}, 8'd0);

        load(1'b1, 1'b1); tick();
        FLG_SHAD_PUSH = 1'b1; FLG_SHAD_POP = 1'b1; tick();
        chk_st("pp_empty", 1'b1, 1'b1, 1);
        chk_val("pp_empty_unf", {7'd0, SHAD_UNF}, 8'd0);
        load(1'b0, 1'b1); tick();
        FLG_SHAD_PUSH = 1'b1; tick();
        load(1'b1, 1'b0); tick();
        retie(); FLG_SHAD_PUSH = 1'b1; tick();
        chk_st("pp_d2", 1'b0, 1'b1, 2);
        retie(); tick();
        chk_st("pp_top", 1'b1, 1'b0, 1);
        retie(); tick();
        chk_st("pp_bottom", 1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/flag_reg_shadow.md
Name: flag_reg_shadow

Overview:
- Sequential C/Z flag stage directly downstream of the C/Z flag-select muxes in the RAT MCU datapath.
- Holds the architectural C and Z flags and a LIFO shadow stack that saves the flags on interrupt entry and restores them on RETIE.
- Supports nested interrupts up to DEPTH levels.
- Feeds C_FLAG to the ALU carry-in and branch logic, and Z_FLAG to branch logic.

Parameters:
- DEPTH, 4, number of shadow stack entries (≥1); each entry holds {C,Z}.
- PTR_W, $clog2(DEPTH+1), width of SHAD_DEPTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- C_IN  in  1  ALU carry result.
- Z_IN  in  1  ALU zero result.
- FLG_C_SET  in  1  force C=1.
- FLG_C_CLR  in  1  force C=0.
- FLG_C_LD  in  1  load C from the selected source.
- FLG_Z_LD  in  1  load Z from the selected source.
- FLG_LD_SEL  in  1  0: source is C_IN/Z_IN; 1: source is the shadow stack top.
- FLG_SHAD_PUSH  in  1  push current {C_FLAG,Z_FLAG} (interrupt entry).
- FLG_SHAD_POP  in  1  pop the stack top (RETIE).
- FLG_ERR_CLR  in  1  clear sticky error flags.
- C_FLAG  out  1  registered C.
- Z_FLAG  out  1  registered Z.
- SHAD_DEPTH  out  PTR_W  number of valid stack entries, 0..DEPTH.
- SHAD_OVF  out  1  sticky: a push was attempted while full.
- SHAD_UNF  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: RST_N low asynchronously sets C_FLAG=0, Z_FLAG=0, SHAD_DEPTH=0, SHAD_OVF=0, SHAD_UNF=0, all stack entries 0. Reset mid-operation discards any in-flight update.
- Reset release: the first rising edge with RST_N high may update state.
- Stack top:
  - TOP = entry[SHAD_DEPTH-1] when SHAD_DEPTH>0.
  - TOP = {0,0} when empty.
  - TOP is combinational from current state (pre-edge).
- Flag source: FLG_LD_SEL=0 uses C_IN/Z_IN; FLG_LD_SEL=1 uses TOP.C/TOP.Z.
- C next-state priority: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
- Z next-state: FLG_Z_LD loads the selected source, else hold.
- Latency: all flag updates are visible on the outputs one cycle after the controlling edge.
- Push (PUSH=1, POP=0):
  - Not full: entry[SHAD_DEPTH] ← {C_FLAG,Z_FLAG} (pre-edge values, not the same-cycle next values); SHAD_DEPTH+1.
  - Full (SHAD_DEPTH==DEPTH): no write, depth unchanged, SHAD_OVF←1.
- Pop (POP=1, PUSH=0):
  - Not empty: SHAD_DEPTH−1; the entry is not cleared.
  - Empty: depth stays 0, SHAD_UNF←1.
- Restore: restore is not implied by pop. A RETIE cycle asserts FLG_LD_SEL=1, FLG_C_LD=1, FLG_Z_LD=1 and POP=1 together. Flags take the pre-pop TOP.
- PUSH and POP in the same cycle:
  - Depth ≥1: TOP entry ← pre-edge {C_FLAG,Z_FLAG}, depth unchanged; any same-cycle restore uses the old TOP.
  - Depth 0: treated as a push (depth→1); SHAD_UNF is not set.
- Error flags:
  - FLG_ERR_CLR clears SHAD_OVF and SHAD_UNF.
  - If an error event occurs in the same cycle, the set wins.
- Implementation constraints:
  - Depth counter never wraps.
  - SHAD_DEPTH saturates at DEPTH and at 0.
  - No combinational path from inputs to C_FLAG/Z_FLAG.

Test Plan:
- Reset/priority: hold RST_N low mid-clock → all outputs 0 immediately. Release, then assert C_IN=1, FLG_C_LD=1, FLG_C_SET=1, FLG_C_CLR=1 → C_FLAG=0. Drop CLR → C_FLAG=1.
- Save/restore: C=1,Z=0, PUSH → depth=1. ALU loads C=0,Z=1. Then RETIE cycle (SEL=1, C_LD, Z_LD, POP) → C_FLAG=1, Z_FLAG=0, depth=0.
- Nesting DEPTH=4: push {1,1},{0,1},{1,0},{0,0} with flags changed between pushes; four RETIE cycles → flags restore in reverse order: {0,0},{1,0},{0,1},{1,1}.
- Overflow: 5 pushes at DEPTH=4 → depth=4, SHAD_OVF=1, stack contents unchanged. FLG_ERR_CLR → SHAD_OVF=0.
- Underflow: RETIE at depth 0 → C_FLAG=0, Z_FLAG=0, SHAD_UNF=1, depth=0.
- Simultaneous push+pop at depth 2 with flags {1,0} and SEL=1 loads → flags take old TOP, TOP becomes {1,0}, depth=2.
